ddr_serializer: RTL

DDR_SERIALIZER -- requirements
Module: ddr_serializer

---
 rtl/ice40_io_pkg.sv | 11 +
 rtl/ddr_serializer.sv | 110 +++++++++++
 2 files changed

// File: rtl/ice40_io_pkg.sv
// Shared iCE40 I/O constants for parents that wrap serializers in SB_IO pads.
package ice40_io_pkg;

   // PIN_TYPE[5:2] = 4'b0100: registered DDR output (D_OUT_0 on rise, D_OUT_1 on fall).
   // PIN_TYPE[1:0] = 2'b01  : simple (unregistered) input path, unused by output-only pads.
   localparam logic [5:0] SB_IO_PIN_TYPE_DDR_OUT = 6'b0100_01;

   // Output enable is not used by a plain DDR output pad; parents tie it high.
   localparam logic SB_IO_OUTPUT_ENABLE_ON = 1'b1;

endpackage : ice40_io_pkg

// File: rtl/ddr_serializer.sv
// Parallel-to-DDR serializer: one WIDTH-bit word becomes WIDTH/2 bit pairs,
// LSB first, presented on d_out_0 (rising-edge bit) and d_out_1 (falling-edge bit)
// for an SB_IO DDR output register clocked by the same clk.
module ddr_serializer #(
   parameter int unsigned WIDTH      = 10,
   parameter logic        IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             d_out_0,
   output logic             d_out_1,
   output logic             busy,
   output logic             underrun
);

   localparam int unsigned PAIRS = WIDTH / 2;
   localparam int unsigned CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
   localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(PAIRS - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] hold;
   logic             hold_full;
   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] cnt;

   logic accept_c;
   logic word_end_c;
   logic load_c;
   logic hold_full_nxt_c;

   // Handshake, end-of-word and hold-to-shifter transfer decisions for this edge.
   always_comb begin
      accept_c        = din_valid & din_ready;
      word_end_c      = (state == SHIFT) && (cnt == LAST_PAIR);
      load_c          = hold_full && ((state == IDLE) || word_end_c);
      // A word accepted on the same edge the held word moves out keeps hold full.
      hold_full_nxt_c = accept_c | (hold_full & ~load_c);
   end

   // One-entry holding register; din_ready mirrors its next emptiness so it is registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold      <= '0;
         hold_full <= 1'b0;
         din_ready <= 1'b0;
      end else begin
         if (accept_c) begin
            hold <= din;
         end
         hold_full <= hold_full_nxt_c;
         din_ready <= ~hold_full_nxt_c;
      end
   end

   // IDLE/SHIFT controller: loads words, walks the pairs and flags stream ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         shreg    <= '0;
         cnt      <= '0;
         d_out_0  <= IDLE_LEVEL;
         d_out_1  <= IDLE_LEVEL;
         busy     <= 1'b0;
         underrun <= 1'b0;
      end else begin
         underrun <= 1'b0;
         if (load_c) begin
            // Pair 0 goes straight to the pads; the shifter keeps pairs 1.. at its bottom.
            shreg   <= hold >> 2;
            d_out_0 <= hold[0];
            d_out_1 <= hold[1];
            cnt     <= '0;
            state   <= SHIFT;
            busy    <= 1'b1;
         end else begin
            case (state)
               SHIFT: begin
                  if (word_end_c) begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     cnt      <= '0;
                     d_out_0  <= IDLE_LEVEL;
                     d_out_1  <= IDLE_LEVEL;
                     underrun <= 1'b1;
                  end else begin
                     cnt     <= cnt + CNT_W'(1);
                     shreg   <= shreg >> 2;
                     d_out_0 <= shreg[0];
                     d_out_1 <= shreg[1];
                  end
               end
               default: begin
                  d_out_0 <= IDLE_LEVEL;
                  d_out_1 <= IDLE_LEVEL;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule : ddr_serializer
